// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 256x32 single-port data memory.
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 1024,
    parameter int unsigned RR_INIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0] perf_grant0,
    output logic [15:0] perf_grant1,
    output logic [15:0] perf_conflict
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic RR_RESET = (RR_INIT != 0);

    state_t      state;
    state_t      state_nx;
    logic        rr_ptr;
    logic        grant_id;
    logic        grant_any;
    logic        acc_err;
    logic        lat_id;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // A lone requester wins outright; a tie goes to the port holding the pointer.
    always_comb begin
        grant_id  = rr_ptr;
        grant_any = rst_n && (state == IDLE) && (req_valid != 2'b00);
        if (req_valid == 2'b01) begin
            grant_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
    end

    assign acc_err    = (lat_addr[1:0] != 2'b00) || (lat_addr >= ADDR_LIMIT);
    assign address    = lat_addr;
    assign write_data = lat_wdata;

    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_id] = 1'b1;
                    state_nx            = ACCESS;
                end
            end
            ACCESS: begin
                mem_write = !acc_err && lat_write;
                mem_read  = !acc_err && !lat_write;
                state_nx  = RESP;
            end
            RESP: begin
                rsp_valid[lat_id] = 1'b1;
                if (rsp_ready[lat_id]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request capture on handshake; response capture at the end of the access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= RR_RESET;
            lat_id    <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (grant_any) begin
                rr_ptr    <= ~grant_id;
                lat_id    <= grant_id;
                lat_write <= req_write[grant_id];
                lat_addr  <= grant_id ? req_addr1 : req_addr0;
                lat_wdata <= grant_id ? req_wdata1 : req_wdata0;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (!acc_err && !lat_write) ? read_data : 32'h0;
                rsp_err   <= acc_err;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0   <= 16'h0;
            perf_grant1   <= 16'h0;
            perf_conflict <= 16'h0;
        end else begin
            if (grant_any && !grant_id && (perf_grant0 != 16'hFFFF)) begin
                perf_grant0 <= perf_grant0 + 16'd1;
            end
            if (grant_any && grant_id && (perf_grant1 != 16'hFFFF)) begin
                perf_grant1 <= perf_grant1 + 16'd1;
            end
            if ((state == IDLE) && (req_valid == 2'b11) && (perf_conflict != 16'hFFFF)) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [31:0] req_addr0 = 32'h0;
    logic [31:0] req_addr1 = 32'h0;
    logic [31:0] req_wdata0 = 32'h0;
    logic [31:0] req_wdata1 = 32'h0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_grant0;
    logic [15:0] perf_grant1;
    logic [15:0] perf_conflict;
`endif

    int vectors = 0;
    int miscompares = 0;
    int mw_count = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LIMIT(1024), .RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data)
`ifdef DMEM_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
    );

    // Memory attached to the DUT, and an independent copy updated only by the model.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 + i;
            ref_mem[i] = 32'hA500_0000 + i;
        end
    end
    assign read_data = mem[address[9:2]];
    always @(posedge clk) if (mem_write) mem[address[9:2]] <= write_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr < 1024);
    endfunction

    // Transaction-level model: idle, or busy with a request that is phase 0 (access) or responding.
    bit          m_busy = 0;
    int          m_phase = 0;
    bit          m_id = 0;
    bit          m_write = 0;
    bit          m_ptr = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    logic [31:0] m_rdata = 0;
    bit          m_err = 0;
    int          m_g0 = 0, m_g1 = 0, m_conf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_phase = 0; m_id = 0; m_write = 0; m_ptr = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0;
            m_g0 = 0; m_g1 = 0; m_conf = 0;
        end else if (!m_busy) begin
            if (req_valid == 2'b11 && m_conf < 65535) m_conf++;
            if (req_valid != 2'b00) begin
                bit g;
                g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
                m_id    = g;
                m_write = req_write[g];
                m_addr  = g ? req_addr1 : req_addr0;
                m_wdata = g ? req_wdata1 : req_wdata0;
                m_ptr   = !g;
                m_busy  = 1;
                m_phase = 0;
                if (g == 0 && m_g0 < 65535) m_g0++;
                if (g == 1 && m_g1 < 65535) m_g1++;
            end
        end else if (m_phase == 0) begin
            m_err   = !is_legal(m_addr);
            m_rdata = (!m_err && !m_write) ? ref_mem[int'(m_addr / 4)] : 32'h0;
            if (!m_err && m_write) ref_mem[int'(m_addr / 4)] = m_wdata;
            m_phase = 1;
        end else if (rsp_ready[m_id]) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e_ready, e_rv;
        logic       e_mw, e_mr;
        if (mem_write) mw_count++;
        e_ready = 2'b00; e_rv = 2'b00; e_mw = 0; e_mr = 0;
        if (rst_n) begin
            if (!m_busy) begin
                if (req_valid == 2'b11) e_ready[m_ptr] = 1'b1;
                else e_ready = req_valid;
            end else if (m_phase == 0) begin
                e_mw = is_legal(m_addr) && m_write;
                e_mr = is_legal(m_addr) && !m_write;
            end else begin
                e_rv[m_id] = 1'b1;
            end
        end
        check_output("req_ready", req_ready, e_ready);
        check_output("rsp_valid", rsp_valid, e_rv);
        check_output("rsp_rdata", rsp_rdata, m_rdata);
        check_output("rsp_err", rsp_err, m_err);
        check_output("address", address, m_addr);
        check_output("write_data", write_data, m_wdata);
        check_output("mem_write", mem_write, e_mw);
        check_output("mem_read", mem_read, e_mr);
`ifdef DMEM_ARB_PERF_EN
        check_output("perf_grant0", perf_grant0, m_g0[15:0]);
        check_output("perf_grant1", perf_grant1, m_g1[15:0]);
        check_output("perf_conflict", perf_conflict, m_conf[15:0]);
`endif
    end

    // Issue one request, wait for accept, then wait for its response (rsp_ready assumed high).
    task automatic apply_stimulus(input bit port, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic err, output int lat);
        bit accepted = 0;
        bit got = 0;
        @(posedge clk); #1;
        req_valid[port] = 1'b1;
        req_write[port] = wr;
        if (port) begin req_addr1 = addr; req_wdata1 = wdata; end
        else      begin req_addr0 = addr; req_wdata0 = wdata; end
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (req_ready[port]) accepted = 1;
            @(posedge clk); #1;
        end
        check_output("accept_in_time", accepted, 1);
        req_valid[port] = 1'b0;
        lat = 0; rdata = 32'h0; err = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[port]) begin
                got = 1; rdata = rsp_rdata; err = rsp_err;
            end
        end
        check_output("response_in_time", got, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          grants, nrsp;
        bit          g_order [8];
        bit          r_order [8];
        bit          exp_order [4] = '{0, 1, 0, 1};

        // Reset values
        #2;
        check_output("reset_req_ready", req_ready, 2'b00);
        check_output("reset_rsp_valid", rsp_valid, 2'b00);
        check_output("reset_address", address, 32'h0);
        do_reset();

        // Contention from reset: strict alternation starting at port 0
        req_addr0 = 32'h40; req_addr1 = 32'h80; req_write = 2'b00;
        req_valid = 2'b11;
        grants = 0; nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && grants < 8) begin g_order[grants] = req_ready[1]; grants++; end
            if (rsp_valid != 2'b00 && nrsp < 8) begin r_order[nrsp] = rsp_valid[1]; nrsp++; end
            @(posedge clk); #1;
            if (grants == 4) req_valid = 2'b00;
        end
        check_output("contention_grants", grants, 4);
        check_output("contention_rsps", nrsp, 4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("grant_order%0d", i), g_order[i], exp_order[i]);
            check_output($sformatf("rsp_order%0d", i), r_order[i], exp_order[i]);
        end
`ifdef DMEM_ARB_PERF_EN
        check_output("perf_grant0_lit", perf_grant0, 2);
        check_output("perf_grant1_lit", perf_grant1, 2);
        check_output("perf_conflict_lit", perf_conflict, 4);
`endif

        // Port 0 write then read-back
        mw_count = 0;
        apply_stimulus(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check_output("write_err", er, 0);
        check_output("write_rdata", rd, 0);
        check_output("write_mw_pulses", mw_count, 1);
        check_output("write_mem", mem[4], 32'hDEADBEEF);
        apply_stimulus(0, 0, 32'h10, 32'h0, rd, er, lat);
        check_output("read_rdata", rd, 32'hDEADBEEF);
        check_output("read_err", er, 0);
        check_output("read_latency", lat, 2);

        // Port 1 error writes: misaligned and out of range
        mw_count = 0;
        apply_stimulus(1, 1, 32'h12, 32'h55, rd, er, lat);
        check_output("misalign_err", er, 1);
        check_output("misalign_rdata", rd, 0);
        apply_stimulus(1, 1, 32'h400, 32'h55, rd, er, lat);
        check_output("range_err", er, 1);
        check_output("range_rdata", rd, 0);
        check_output("err_no_mw", mw_count, 0);
        check_output("err_mem4", mem[4], 32'hDEADBEEF);
        check_output("err_mem0", mem[0], 32'hA500_0000);

        // Response back-pressure on port 0 while port 1 waits
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        req_write = 2'b00; req_addr0 = 32'h10; req_addr1 = 32'h80;
        req_valid = 2'b01;
        @(negedge clk);
        check_output("hold_accept0", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        check_output("hold_access_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("hold_rsp_valid", rsp_valid, 2'b01);
            check_output("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check_output("hold_err", rsp_err, 0);
            check_output("hold_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        @(negedge clk);
        check_output("hold_then_grant1", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);
        #1;

        // Reset during the access cycle of a write to 0x20
        req_write = 2'b01; req_addr0 = 32'h20; req_wdata0 = 32'hCAFEF00D;
        req_valid = 2'b01;
        @(posedge clk); #3;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        check_output("rst_mem_write", mem_write, 0);
        check_output("rst_address", address, 32'h0);
        check_output("rst_write_data", write_data, 32'h0);
        check_output("rst_rsp_valid", rsp_valid, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_output("rst_mem20", mem[8], 32'hA500_0008);
        req_write = 2'b00; req_addr0 = 32'h20; req_addr1 = 32'h24;
        req_valid = 2'b11;
        @(negedge clk);
        check_output("rst_pointer", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
